// File: rtl/flash_arbiter_if.sv
// Bundle between the flash read arbiter, its two requesters and the flash controller.
interface flash_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              ready0;
  logic              ready1;
  logic [ADDR_W-1:0] flashReadAddr;
  logic              flashEnabled;
  logic [DATA_W-1:0] flashByteRead;
  logic              flashDataReady;
  logic              busy;
  logic              timeout;

  // Requesters plus flash controller side.
  modport master (
    output req0, req1, addr0, addr1, flashByteRead, flashDataReady,
    input  data0, data1, ready0, ready1, flashReadAddr, flashEnabled, busy, timeout
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, addr0, addr1, flashByteRead, flashDataReady,
    output data0, data1, ready0, ready1, flashReadAddr, flashEnabled, busy, timeout
  );
endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing one flash read port between two requesters.
// Strobe rises the cycle after a grant; ready pulses the cycle after data is sampled or TIMEOUT expires.
module flash_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  flash_arbiter_if.slave fa
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              gnt;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic              rdy0;
  logic              rdy1;
  logic              to_pulse;
  logic              pick;
  logic              finish;
  logic [DATA_W-1:0] rd_val;

  // On a tie the requester not served last wins; a lone request wins outright.
  assign pick   = (fa.req0 && fa.req1) ? ~last_grant : fa.req1;
  assign finish = fa.flashDataReady || (cnt == LAST_CNT);
  assign rd_val = fa.flashDataReady ? fa.flashByteRead : {DATA_W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rd_addr    <= '0;
      rd_en      <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      rdy0       <= 1'b0;
      rdy1       <= 1'b0;
      to_pulse   <= 1'b0;
    end else begin
      rdy0     <= 1'b0;
      rdy1     <= 1'b0;
      to_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (fa.req0 || fa.req1) begin
            gnt        <= pick;
            last_grant <= pick;
            rd_addr    <= pick ? fa.addr1 : fa.addr0;
            rd_en      <= 1'b1;
            cnt        <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (finish) begin
            if (gnt) begin
              d1   <= rd_val;
              rdy1 <= 1'b1;
            end else begin
              d0   <= rd_val;
              rdy0 <= 1'b1;
            end
            // Data arriving on the last allowed cycle still counts as a normal read.
            to_pulse <= ~fa.flashDataReady;
            rd_en    <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!fa.flashDataReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fa.data0         = d0;
  assign fa.data1         = d1;
  assign fa.ready0        = rdy0;
  assign fa.ready1        = rdy1;
  assign fa.flashReadAddr = rd_addr;
  assign fa.flashEnabled  = rd_en;
  assign fa.busy          = (state != IDLE);
  assign fa.timeout       = to_pulse;
endmodule

// File: tb/tb_flash_arbiter.sv
// Randomised bench: requesters push expected results, a monitor pops and checks on every ready pulse.
module tb_flash_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  flash_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fa ();

  flash_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .fa    (fa)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Flash content, response delay (in WAIT cycles) and ready hold length are all functions of the address.
  function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo - 8'h0E, lo - 8'h0F} ^ {a[23:16], a[15:8]};
  endfunction

  function automatic int resp_delay(input logic [AW-1:0] a);
    return (int'(a[3:0]) + 3) % 16;
  endfunction

  function automatic int hold_len(input logic [AW-1:0] a);
    return int'(a[5:4]) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic request(input int id, input logic [AW-1:0] a);
    exp_t e;
    bit   seen;
    e.to   = (resp_delay(a) >= TO);
    e.data = e.to ? {DW{1'b1}} : flash_word(a);
    seen   = 1'b0;
    @(posedge clk); #1;
    if (id == 0) begin
      fa.req0 = 1'b1; fa.addr0 = a; q0.push_back(e);
    end else begin
      fa.req1 = 1'b1; fa.addr1 = a; q1.push_back(e);
    end
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 0) ? fa.ready0 : fa.ready1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_wait req%0d: no ready within 200 cycles, required one pulse", id);
    end
    @(posedge clk); #1;
    if (id == 0) fa.req0 = 1'b0;
    else         fa.req1 = 1'b0;
  endtask

  // Flash controller model.
  logic [AW-1:0] fl_addr;
  initial begin
    fa.flashDataReady = 1'b0;
    fa.flashByteRead  = '0;
    forever begin
      @(posedge clk); #1;
      fa.flashByteRead = DW'($urandom);
      if (fa.flashEnabled && !fa.flashDataReady) begin
        fl_addr = fa.flashReadAddr;
        if (resp_delay(fl_addr) < TO) begin
          repeat (resp_delay(fl_addr)) begin
            @(posedge clk); #1;
            fa.flashByteRead = DW'($urandom);
          end
          fa.flashDataReady = 1'b1;
          fa.flashByteRead  = flash_word(fl_addr);
          repeat (hold_len(fl_addr)) @(posedge clk);
          #1;
          fa.flashDataReady = 1'b0;
        end else begin
          while (fa.flashEnabled) begin
            @(posedge clk); #1;
            fa.flashByteRead = DW'($urandom);
          end
        end
      end
    end
  end

  // Monitor with round-robin grant model and scoreboard.
  logic          last_g, g;
  logic [DW-1:0] md0, md1;
  logic          pr0, pr1, pfe, prst, pfdr, prdy0, prdy1;
  logic [AW-1:0] pa0, pa1, held_addr;
  exp_t          e;
  initial begin
    last_g = 1'b1; md0 = '0; md1 = '0;
    pr0 = 0; pr1 = 0; pfe = 0; prst = 0; pfdr = 0; prdy0 = 0; prdy1 = 0;
    pa0 = '0; pa1 = '0; held_addr = '0;
    forever begin
      @(negedge clk);
      if (prst) begin
        last_g = 1'b1; md0 = '0; md1 = '0;
        check("rst_flashEnabled", fa.flashEnabled, 0);
        check("rst_flashReadAddr", fa.flashReadAddr, 0);
        check("rst_data0", fa.data0, 0);
        check("rst_data1", fa.data1, 0);
        check("rst_ready", {fa.ready0, fa.ready1}, 0);
        check("rst_timeout", fa.timeout, 0);
        check("rst_busy", fa.busy, 0);
      end else begin
        if (fa.flashEnabled && !pfe) begin
          check("grant_has_req", pr0 | pr1, 1);
          check("grant_fdr_low", pfdr, 0);
          g = (pr0 && pr1) ? ~last_g : pr1;
          last_g = g;
          check("grant_addr", fa.flashReadAddr, g ? pa1 : pa0);
          held_addr = fa.flashReadAddr;
        end else if (fa.flashEnabled) begin
          check("addr_stable", fa.flashReadAddr, held_addr);
        end
        check("ready_excl", fa.ready0 & fa.ready1, 0);
        check("timeout_with_ready", fa.timeout & ~(fa.ready0 | fa.ready1), 0);
        if (fa.ready0) begin
          check("ready0_single", prdy0, 0);
          check("ready0_strobe_off", fa.flashEnabled, 0);
          check("ready0_busy", fa.busy, 1);
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL ready0_unexpected: pulse with no outstanding request, required none");
          end else begin
            e = q0.pop_front();
            check("data0", fa.data0, e.data);
            check("timeout0", fa.timeout, e.to);
            md0 = e.data;
          end
        end
        if (fa.ready1) begin
          check("ready1_single", prdy1, 0);
          check("ready1_strobe_off", fa.flashEnabled, 0);
          check("ready1_busy", fa.busy, 1);
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL ready1_unexpected: pulse with no outstanding request, required none");
          end else begin
            e = q1.pop_front();
            check("data1", fa.data1, e.data);
            check("timeout1", fa.timeout, e.to);
            md1 = e.data;
          end
        end
        check("data0_hold", fa.data0, md0);
        check("data1_hold", fa.data1, md1);
      end
      pr0 = fa.req0; pr1 = fa.req1; pa0 = fa.addr0; pa1 = fa.addr1;
      pfe = fa.flashEnabled; prst = reset; pfdr = fa.flashDataReady;
      prdy0 = fa.ready0; prdy1 = fa.ready1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    fa.req0 = 1'b0; fa.req1 = 1'b0; fa.addr0 = '0; fa.addr1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Two ties from reset: requester 0 wins both.
    fork
      request(0, 24'h001234);
      request(1, 24'h805678);
    join
    fork
      request(0, 24'h002231);
      request(1, 24'h8000A2);
    join

    request(0, 24'h000010);
    request(1, 24'h800005);
    request(1, 24'h800004);
    request(0, 24'h000031);

    fork
      for (int k = 0; k < 25; k++) begin
        request(0, {1'b0, 23'($urandom)});
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int k = 0; k < 25; k++) begin
        request(1, {1'b1, 23'($urandom)});
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    join

    // Reset in the middle of a read; the still-pending request is served afterwards.
    fork
      request(0, 24'h000007);
      begin
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
      end
    join

    repeat (10) @(posedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
